tlul_host_adapter: RTL and testbench

TLUL_HOST_ADAPTER -- requirements
Module: tlul_host_adapter

---
 rtl/tlul_host_adapter.sv | 156 +++++++++++++++
 tb/tb_tlul_host_adapter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_adapter.sv
// Core-side request/response bridge onto a TL-UL host port: one A beat per
// accepted request, in-order D responses, and error flagging for responses
// that do not match what is outstanding.
module tlul_host_adapter #(
  parameter int TL_AW   = 32,
  parameter int TL_DW   = 32,
  parameter int TL_AIW  = 8,
  parameter int TL_DBW  = TL_DW >> 3,
  parameter int TL_SZW  = $clog2($clog2(TL_DBW) + 1),
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  // core side
  input  logic              req,
  output logic              gnt,
  input  logic              we,
  input  logic [TL_AW-1:0]  addr,
  input  logic [TL_DW-1:0]  wdata,
  input  logic [TL_DBW-1:0] be,
  output logic              rvalid,
  output logic [TL_DW-1:0]  rdata,
  output logic              err,
  // TL-UL A channel
  output logic              a_valid,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [TL_SZW-1:0] a_size,
  output logic [TL_AIW-1:0] a_source,
  output logic [TL_AW-1:0]  a_address,
  output logic [TL_DBW-1:0] a_mask,
  output logic [TL_DW-1:0]  a_data,
  input  logic              a_ready,
  // TL-UL D channel
  input  logic              d_valid,
  input  logic [2:0]        d_opcode,
  input  logic [2:0]        d_param,
  input  logic [TL_SZW-1:0] d_size,
  input  logic [TL_AIW-1:0] d_source,
  input  logic              d_sink,
  input  logic [TL_DW-1:0]  d_data,
  input  logic              d_error,
  output logic              d_ready
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    OP_ACK      = 3'd0,
    OP_ACK_DATA = 3'd1
  } d_op_e;

  logic [PW-1:0]      src_ptr;
  logic [PW-1:0]      exp_src;
  logic [OW-1:0]      outstanding;
  logic [MAX_OUT-1:0] we_tbl;

  logic  core_hs;
  logic  d_hs;
  logic  d_expected;
  logic  d_bad;
  a_op_e a_opcode_next;
  d_op_e d_opcode_exp;

  // d_param, d_size and d_sink carry nothing this adapter acts on.
  logic unused_d;
  assign unused_d = ^{d_param, d_size, d_sink};

  assign d_ready    = rstn;
  assign gnt        = rstn & (!a_valid | a_ready) & (outstanding < OW'(MAX_OUT));
  assign core_hs    = req & gnt;
  assign d_hs       = d_valid & d_ready;
  assign d_expected = (outstanding != '0);

  // Opcode selection for the next A beat and validation of the current D beat.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    a_opcode_next = OP_GET;
    d_opcode_exp  = OP_ACK_DATA;
    if (we) a_opcode_next = (&be) ? OP_PUT_FULL : OP_PUT_PARTIAL;
    if (we_tbl[exp_src]) d_opcode_exp = OP_ACK;
    d_bad = d_error
          | (d_source != TL_AIW'(exp_src))
          | (d_opcode != d_opcode_exp)
          | !d_expected;
  end

  // A-channel register: loads on handshake, holds under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      a_valid   <= 1'b0;
      a_opcode  <= '0;
      a_param   <= '0;
      a_size    <= '0;
      a_source  <= '0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
    end else if (core_hs) begin
      a_valid   <= 1'b1;
      a_opcode  <= a_opcode_next;
      a_param   <= '0;
      a_size    <= TL_SZW'($clog2(TL_DBW));
      a_source  <= TL_AIW'(src_ptr);
      a_address <= addr;
      a_mask    <= we ? be : '1;
      a_data    <= we ? wdata : '0;
    end else if (a_ready) begin
      a_valid   <= 1'b0;
    end
  end

  // Source allocation, per-source write flag, and outstanding count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_ptr     <= '0;
      exp_src     <= '0;
      outstanding <= '0;
      // NOTE: the write-flag table is a handful of flops, so it is reset like any other state.
      we_tbl      <= '0;
    end else begin
      if (core_hs) begin
        src_ptr         <= src_ptr + 1'b1;
        we_tbl[src_ptr] <= we;
      end
      if (d_hs && d_expected) exp_src <= exp_src + 1'b1;
      case ({core_hs, d_hs && d_expected})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Core response: one-cycle pulse the cycle after each D beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= d_hs;
      err    <= d_hs & d_bad;
      if (d_hs) rdata <= (d_opcode == OP_ACK_DATA) ? d_data : '0;
    end
  end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Self-checking bench for tlul_host_adapter: A-channel fields are compared
// inline per scenario; D responses go through an expected-response queue.
module tb_tlul_host_adapter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, gnt, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rvalid, err;
  logic [31:0] rdata;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_sink, d_error, d_ready;
  logic [2:0]  d_opcode, d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;

  tlul_host_adapter dut (
    .clk(clk), .rstn(rstn),
    .req(req), .gnt(gnt), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rvalid(rvalid), .rdata(rdata), .err(err),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
    .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          beats = 0;
  int          src_m = 0;
  int          exp_m = 0;
  logic [84:0] a_obs;

  assign a_obs = {a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_valid && a_ready) beats <= beats + 1;
  end

  // Response monitor: every rvalid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (rdata !== mon_e.rdata || err !== mon_e.err || cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL response: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   rdata, err, cyc, mon_e.rdata, mon_e.err, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one core request and return at the negedge after it was accepted.
  task automatic issue(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] b);
    int k;
    @(negedge clk);
    req = 1'b1; we = w; addr = ad; wdata = wd; be = b;
    #1;
    k = 0;
    while (gnt !== 1'b1 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (gnt !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_timeout: got gnt=%b after 20 cycles, required 1", gnt);
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    src_m = (src_m + 1) % 4;
  endtask

  // Drive one D beat and queue the response it should produce a cycle later.
  task automatic drive_d(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data,
                         input logic e, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t x;
    @(negedge clk);
    d_valid = 1'b1; d_opcode = op; d_source = src; d_data = data; d_error = e;
    d_param = 3'($urandom_range(7)); d_size = 2'($urandom_range(3)); d_sink = 1'($urandom_range(1));
    x.rdata = exp_rdata; x.err = exp_err; x.cyc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    d_valid = 1'b0; d_error = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0; a_ready = 1'b1;
    d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0; d_source = '0;
    d_sink = 1'b0; d_data = '0; d_error = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, a_valid, rvalid, err, d_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got gnt/a_valid/rvalid/err/d_ready=%b, required 00000",
               {gnt, a_valid, rvalid, err, d_ready});
    end
    n_cmp++;
    if (a_obs !== '0 || rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got a=%h rdata=%h, required all zero", a_obs, rdata);
    end
    req = 1'b0;
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 1'b1 || d_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got gnt=%b d_ready=%b, required 1 1", gnt, d_ready);
    end
  endtask

  task automatic test_read();
    int s;
    a_ready = 1'b1;
    s = src_m;
    issue(1'b0, 32'h100, 32'hDEADBEEF, 4'h3);
    n_cmp++;
    if (a_obs !== {1'b1, 3'd4, 3'd0, 2'd2, 8'(s), 32'h100, 4'hF, 32'h0}) begin
      n_bad++;
      $display("FAIL read_a: got %h, required %h", a_obs,
               {1'b1, 3'd4, 3'd0, 2'd2, 8'(s), 32'h100, 4'hF, 32'h0});
    end
    @(negedge clk);
    n_cmp++;
    if (a_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL read_a_clear: got a_valid=%b, required 0", a_valid);
    end
    drive_d(3'd1, 8'(exp_m), 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0);
    exp_m = (exp_m + 1) % 4;
  endtask

  task automatic test_write();
    int s;
    a_ready = 1'b1;
    s = src_m;
    issue(1'b1, 32'h200, 32'h11223344, 4'hF);
    n_cmp++;
    if (a_obs !== {1'b1, 3'd0, 3'd0, 2'd2, 8'(s), 32'h200, 4'hF, 32'h11223344}) begin
      n_bad++;
      $display("FAIL write_full_a: got %h, required %h", a_obs,
               {1'b1, 3'd0, 3'd0, 2'd2, 8'(s), 32'h200, 4'hF, 32'h11223344});
    end
    issue(1'b1, 32'h204, 32'h11223344, 4'h3);
    n_cmp++;
    if (a_obs !== {1'b1, 3'd1, 3'd0, 2'd2, 8'((s + 1) % 4), 32'h204, 4'h3, 32'h11223344}) begin
      n_bad++;
      $display("FAIL write_partial_a: got %h, required %h", a_obs,
               {1'b1, 3'd1, 3'd0, 2'd2, 8'((s + 1) % 4), 32'h204, 4'h3, 32'h11223344});
    end
    for (int i = 0; i < 2; i++) begin
      drive_d(3'd0, 8'(exp_m), 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
      exp_m = (exp_m + 1) % 4;
    end
  endtask

  task automatic test_backpressure();
    int s;
    int b0;
    logic [84:0] exp_a;
    a_ready = 1'b0;
    s = src_m;
    issue(1'b0, 32'h300, 32'h0, 4'hF);
    exp_a = {1'b1, 3'd4, 3'd0, 2'd2, 8'(s), 32'h300, 4'hF, 32'h0};
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; we = 1'b1; addr = 32'h999; wdata = 32'h5A5A5A5A; be = 4'h1;
      #1;
      n_cmp++;
      if (a_obs !== exp_a || gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold: got a=%h gnt=%b, required a=%h gnt=0", a_obs, gnt, exp_a);
      end
      @(negedge clk);
    end
    req = 1'b0;
    b0 = beats;
    a_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_valid !== 1'b0 || beats != b0 + 1) begin
      n_bad++;
      $display("FAIL backpressure_release: got a_valid=%b beats=%0d, required 0 and %0d",
               a_valid, beats - b0, 1);
    end
    drive_d(3'd1, 8'(exp_m), 32'h12345678, 1'b0, 32'h12345678, 1'b0);
    exp_m = (exp_m + 1) % 4;
  endtask

  task automatic test_limit();
    int s;
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h400 + 32'(i * 4), 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; we = 1'b0; addr = 32'h410; be = 4'hF;
      #1;
      n_cmp++;
      if (gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL limit_gnt_low: got gnt=%b, required 0", gnt);
      end
      @(negedge clk);
    end
    req = 1'b0;
    drive_d(3'd1, 8'(exp_m), 32'hA5A50000, 1'b0, 32'hA5A50000, 1'b0);
    exp_m = (exp_m + 1) % 4;
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL limit_gnt_return: got gnt=%b, required 1", gnt);
    end
    s = src_m;
    issue(1'b0, 32'h410, 32'h0, 4'hF);
    n_cmp++;
    if (a_source !== 8'(s) || a_source !== 8'd0) begin
      n_bad++;
      $display("FAIL limit_wrap_source: got a_source=%0d, required 0", a_source);
    end
    for (int i = 0; i < 4; i++) begin
      drive_d(3'd1, 8'(exp_m), 32'hA5A50001 + 32'(i), 1'b0, 32'hA5A50001 + 32'(i), 1'b0);
      exp_m = (exp_m + 1) % 4;
    end
  endtask

  task automatic test_errors();
    a_ready = 1'b1;
    issue(1'b0, 32'h500, 32'h0, 4'hF);
    drive_d(3'd1, 8'(exp_m), 32'hBAD00001, 1'b1, 32'hBAD00001, 1'b1);
    exp_m = (exp_m + 1) % 4;
    issue(1'b0, 32'h504, 32'h0, 4'hF);
    drive_d(3'd1, 8'((exp_m + 1) % 4), 32'h00000002, 1'b0, 32'h00000002, 1'b1);
    exp_m = (exp_m + 1) % 4;
    issue(1'b1, 32'h508, 32'hFEEDFACE, 4'hF);
    drive_d(3'd1, 8'(exp_m), 32'h00000055, 1'b0, 32'h00000055, 1'b1);
    exp_m = (exp_m + 1) % 4;
    drive_d(3'd0, 8'(exp_m), 32'h00000077, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++;
    if (gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL unexpected_keeps_count: got gnt=%b, required 1", gnt);
    end
    issue(1'b0, 32'h50C, 32'h0, 4'hF);
    drive_d(3'd1, 8'(exp_m), 32'h0000600D, 1'b0, 32'h0000600D, 1'b0);
    exp_m = (exp_m + 1) % 4;
  endtask

  task automatic test_reset_mid();
    a_ready = 1'b1;
    issue(1'b0, 32'h700, 32'h0, 4'hF);
    issue(1'b0, 32'h704, 32'h0, 4'hF);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, a_valid, rvalid, err, d_ready} !== 5'b0 || a_obs !== '0 || rdata !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got ctrl=%b a=%h rdata=%h, required all zero",
               {gnt, a_valid, rvalid, err, d_ready}, a_obs, rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    src_m = 0;
    exp_m = 0;
    issue(1'b0, 32'h800, 32'h0, 4'hF);
    n_cmp++;
    if (a_obs !== {1'b1, 3'd4, 3'd0, 2'd2, 8'd0, 32'h800, 4'hF, 32'h0}) begin
      n_bad++;
      $display("FAIL post_reset_a: got %h, required %h", a_obs,
               {1'b1, 3'd4, 3'd0, 2'd2, 8'd0, 32'h800, 4'hF, 32'h0});
    end
    drive_d(3'd1, 8'd0, 32'h0000F00D, 1'b0, 32'h0000F00D, 1'b0);
    exp_m = 1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_limit();
    test_errors();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_responses: got %0d responses still pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
